// File: rtl/capture_ram_pkg.sv
// capture_ram_pkg: state encoding, CSR offsets and CTRL bit positions for capture_ram
package capture_ram_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_POST = 2'd2, S_DONE = 2'd3} state_t;
  localparam int CSR_CTRL     = 0;
  localparam int CSR_STATUS   = 1;
  localparam int CSR_TRIG_PTR = 2;
  localparam int CSR_POST     = 3;
  localparam int CSR_TSTAMP   = 4;
  localparam int CTRL_ARM     = 0;
  localparam int CTRL_ABORT   = 1;
endpackage

// File: rtl/capture_ram_dpram.sv
// capture_ram_dpram: one write port, one synchronous read-first read port
// Ports: clk; we/waddr/wdata write port; re/raddr read port; q registered read data (holds between reads)
module capture_ram_dpram #(
  parameter int DW = 8,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] q
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) q <= mem[raddr];
  end
endmodule

// File: rtl/capture_ram.sv
// capture_ram: host-accessible capture RAM fed by a sample stream under an arm/trigger/post-trigger FSM
// Ports: clk, rst (async, active-high); in_data/in_valid/trig sample stream;
//   host_addr/host_wdata/host_we/host_re host bus; host_rdata/host_rvalid read return (latency 1);
//   armed (ARMED or POST), capture_done (DONE).
// Option: define CAPTURE_RAM_TSTAMP_EN for a 32-bit cycle counter latched into TSTAMP at the trigger.
module capture_ram
  import capture_ram_pkg::*;
#(
  parameter int AW     = 24,
  parameter int DW     = 32,
  parameter int RAM_DW = 8,
  parameter int RAM_AW = 6,
  parameter int BASE   = 'h100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RAM_DW-1:0] in_data,
  input  logic              in_valid,
  input  logic              trig,
  input  logic [AW-1:0]     host_addr,
  input  logic [DW-1:0]     host_wdata,
  input  logic              host_we,
  input  logic              host_re,
  output logic [DW-1:0]     host_rdata,
  output logic              host_rvalid,
  output logic              armed,
  output logic              capture_done
);
  state_t state_q, state_d;
  logic [RAM_AW-1:0] wptr, trig_ptr, cnt, post_sat;
  logic [RAM_AW:0] post_q;
  logic wrap, in_ram, ctrl_wr, do_abort, do_arm, cap, trig_hit, host_ram_we, rd_ram;
  logic [DW-1:0] csr_rd, rd_csr;
  logic [RAM_DW-1:0] ram_q;
  logic [31:0] tstamp;
  logic unused_ok;
  assign unused_ok = ^host_wdata;
  assign in_ram = host_addr[AW-1:RAM_AW] == (AW-RAM_AW)'(BASE >> RAM_AW);
  assign ctrl_wr = host_we && host_addr == AW'(CSR_CTRL);
  assign do_abort = ctrl_wr && host_wdata[CTRL_ABORT];
  assign do_arm = ctrl_wr && host_wdata[CTRL_ARM] && !do_abort;
  // a sample coinciding with an arm/abort write is not captured
  assign cap = in_valid && !do_abort && !do_arm && (state_q == S_ARMED || state_q == S_POST);
  assign trig_hit = cap && trig && state_q == S_ARMED;
  assign host_ram_we = host_we && in_ram && (state_q == S_IDLE || state_q == S_DONE);
  assign post_sat = post_q[RAM_AW] ? '1 : post_q[RAM_AW-1:0];
  assign host_rdata = rd_ram ? DW'(ram_q) : rd_csr;
  always_comb begin
    state_d = do_abort ? S_IDLE :
              do_arm ? S_ARMED :
              trig_hit ? (post_sat == '0 ? S_DONE : S_POST) :
              (cap && state_q == S_POST && cnt == RAM_AW'(1)) ? S_DONE : state_q;
  end
  always_comb begin
    csr_rd = host_addr == AW'(CSR_STATUS)   ? DW'({wrap, state_q}) :
             host_addr == AW'(CSR_TRIG_PTR) ? DW'(trig_ptr) :
             host_addr == AW'(CSR_POST)     ? DW'(post_q) :
             host_addr == AW'(CSR_TSTAMP)   ? DW'(tstamp) : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      wptr <= '0;
      wrap <= 1'b0;
      trig_ptr <= '0;
      post_q <= '0;
      cnt <= '0;
      armed <= 1'b0;
      capture_done <= 1'b0;
      host_rvalid <= 1'b0;
      rd_ram <= 1'b0;
      rd_csr <= '0;
    end else begin
      state_q <= state_d;
      armed <= state_d == S_ARMED || state_d == S_POST;
      capture_done <= state_d == S_DONE;
      host_rvalid <= host_re;
      if (host_re) begin
        rd_ram <= in_ram;
        rd_csr <= csr_rd;
      end
      if (host_we && host_addr == AW'(CSR_POST)) post_q <= host_wdata[RAM_AW:0];
      if (do_arm) begin
        wptr <= '0;
        wrap <= 1'b0;
      end else if (cap) begin
        wptr <= wptr + 1'b1;
        if (wptr == '1) wrap <= 1'b1;
      end
      if (trig_hit) begin
        trig_ptr <= wptr;
        cnt <= post_sat;
      end else if (cap && state_q == S_POST) cnt <= cnt - 1'b1;
    end
  end
`ifdef CAPTURE_RAM_TSTAMP_EN
  logic [31:0] cyc;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc <= '0;
      tstamp <= '0;
    end else begin
      cyc <= cyc + 1'b1;
      if (do_arm) tstamp <= '0;
      else if (trig_hit) tstamp <= cyc;
    end
  end
`else
  assign tstamp = '0;
`endif
  capture_ram_dpram #(.DW(RAM_DW), .AW(RAM_AW)) u_ram (
    .clk   (clk),
    .we    (cap || host_ram_we),
    .waddr (cap ? wptr : host_addr[RAM_AW-1:0]),
    .wdata (cap ? in_data : host_wdata[RAM_DW-1:0]),
    .re    (host_re && in_ram),
    .raddr (host_addr[RAM_AW-1:0]),
    .q     (ram_q)
  );
endmodule

// File: doc/capture_ram.md
# capture_ram

Parametrised host-accessible capture RAM for GhostBus submodules: generalises the fixed 8×64 host RAM at relative address 0x100 into a configurable-width/depth RAM fed by a local sample stream. Capture is controlled by an arm/trigger/post-trigger state machine. The host reads the captured data and control/status registers over the local host bus. It sits inside a leaf submodule beside user logic.

## Interface
- AW, 24, host address width
- DW, 32, host data width
- RAM_DW, 8, sample/RAM word width (≤ DW)
- RAM_AW, 6, RAM address width (depth 2**RAM_AW)
- BASE, 'h100, relative address of RAM word 0; must be ≥ 8 and aligned to 2**RAM_AW

- clk  in  1  sole clock
- rst  in  1  asynchronous, active-high reset
- in_data  in  RAM_DW  local sample
- in_valid  in  1  sample strobe
- trig  in  1  trigger, sampled only with in_valid
- host_addr  in  AW  relative host address
- host_wdata  in  DW  host write data
- host_we  in  1  host write strobe, single cycle
- host_re  in  1  host read strobe, single cycle
- host_rdata  out  DW  read data
- host_rvalid  out  1  read data valid pulse
- armed  out  1  high in ARMED or POST
- capture_done  out  1  high in DONE

## Operation
- Map (relative): 0 CTRL (W: bit0 arm, bit1 abort; reads 0); 1 STATUS (R: [1:0] state, bit2 wrap); 2 TRIG_PTR (R: RAM address of trigger sample); 3 POST (RW, RAM_AW+1 bits: post-trigger sample count, max 2**RAM_AW−1 used, excess saturates); 4 TSTAMP (see Configuration); BASE..BASE+2**RAM_AW−1 RAM. Other addresses: writes ignored, reads return 0 with rvalid.
- States: IDLE=0, ARMED=1, POST=2, DONE=3.
- arm in any state: wptr←0, wrap←0, state←ARMED. abort: state←IDLE. Both set in the same write: abort wins.
- ARMED: each in_valid writes in_data at wptr, wptr increments modulo depth; wrap←1 on DEPTH−1→0. in_valid&&trig: sample written, TRIG_PTR←wptr, cnt←POST, state←POST, or DONE if POST=0.
- POST: each in_valid writes a sample and decrements cnt; the write that brings cnt to 0 → DONE. trig is ignored.
- IDLE/DONE: in_valid ignored, RAM frozen.
- Host RAM writes take effect only in IDLE or DONE (low RAM_DW bits); silently dropped otherwise. Host RAM reads are allowed in any state, zero-extended to DW.
- Host reading the address the local side writes the same cycle returns old data (read-first).
- host_we and host_re together: both honoured.

## Timing
- Read latency 1: host_re at cycle n → host_rdata/host_rvalid at n+1; rvalid is a one-cycle pulse; rdata holds until the next read.
- CSR writes take effect at the next edge; a sample at the same edge as arm is not captured.
- armed/capture_done are registered from state, with no combinational path from inputs.
- Reset values: host_rdata 0, host_rvalid 0, armed 0, capture_done 0, state IDLE, wptr 0, wrap 0, TRIG_PTR 0, POST 0. RAM contents are not reset. Reset mid-capture returns to IDLE immediately.

## Configuration
- CAPTURE_RAM_TSTAMP_EN defined: 32-bit free-running cycle counter (reset 0, wraps) latched into TSTAMP at the trigger edge; TSTAMP is readable at offset 4 and cleared on arm.
- Not defined: no counter; offset 4 reads 0.

## Structure
- Package capture_ram_pkg: state encoding, CSR offsets, CTRL bit positions.
- Sub-module capture_ram_dpram: RAM_DW×2**RAM_AW, one write port, one synchronous read-first read port. Host and local writes mux onto the write port; they are exclusive by state.

## Test plan
- Reset, then read STATUS/POST/RAM[0] → 0, 0, rvalid one cycle after each re.
- POST=3, arm, feed 0x10..0x14 with trig on 0x11 → DONE after 0x14; TRIG_PTR=1; RAM[0..4]=0x10..0x14; wrap=0.
- POST=0, arm, 70 samples with trig on the 70th → DONE on that cycle, wrap=1, TRIG_PTR=5.
- Host write 0xAB to BASE+2 while ARMED → dropped; same write in DONE → reads back 0x000000AB.
- Write arm|abort → IDLE; assert rst during POST → IDLE, capture_done 0, RAM contents retained.
- With CAPTURE_RAM_TSTAMP_EN: trig at counter 0x57 → TSTAMP=0x57; without the macro → 0.
